// File: rtl/endian_rvs_stream_if.sv
// rtl/endian_rvs_stream_if.sv - valid/ready word stream with last flag
interface endian_rvs_stream_if #(
  parameter int DW = 32
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/endian_rvs_stream.sv
// rtl/endian_rvs_stream.sv - per-packet bit/byte reorder stage with skid-buffered output
module endian_rvs_stream #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic [1:0]           cfg_mode_i,
  endian_rvs_stream_if.slave   s,
  endian_rvs_stream_if.master  m,
  output logic                 busy_o,
  output logic                 mode_chg_o,
  output logic [CNT_W-1:0]     pkt_cnt_o
);

  localparam int NB = DW / 8;

  typedef enum logic {IDLE, PKT} state_t;

  state_t           state_q;
  logic [1:0]       mode_q;
  logic             main_valid_q, main_valid_d;
  logic [DW-1:0]    main_data_q,  main_data_d;
  logic             main_last_q,  main_last_d;
  logic             skid_valid_q, skid_valid_d;
  logic [DW-1:0]    skid_data_q,  skid_data_d;
  logic             skid_last_q,  skid_last_d;
  logic [CNT_W-1:0] pkt_cnt_q,    pkt_cnt_d;

  logic             accept;
  logic             drain;
  logic [1:0]       eff_mode;
  logic [DW-1:0]    xf_data;

  function automatic logic [DW-1:0] reorder(input logic [DW-1:0] d, input logic [1:0] md);
    logic [DW-1:0] r;
    r = d;
    case (md)
      2'd1: for (int k = 0; k < DW; k++) r[DW-1-k] = d[k];
      2'd2: for (int j = 0; j < NB; j++) r[8*j +: 8] = d[8*(NB-1-j) +: 8];
      2'd3: for (int j = 0; j < NB; j++)
              for (int b = 0; b < 8; b++) r[8*j+b] = d[8*j+7-b];
      default: r = d;
    endcase
    return r;
  endfunction

  // Ready depends only on the skid register so m.ready never reaches s.ready.
  assign s.ready  = en_i && !skid_valid_q;
  assign accept   = s.valid && s.ready;
  assign drain    = main_valid_q && m.ready;
  assign eff_mode = (state_q == IDLE) ? cfg_mode_i : mode_q;
  assign xf_data  = reorder(s.data, eff_mode);

  assign m.valid    = main_valid_q;
  assign m.data     = main_data_q;
  assign m.last     = main_last_q;
  assign busy_o     = (state_q == PKT);
  assign mode_chg_o = (state_q == PKT) && (cfg_mode_i != mode_q);
  assign pkt_cnt_o  = pkt_cnt_q;

  // An accept can only happen with the skid empty, so a full skid never coincides with new data.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_last_d  = main_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    if (drain) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_last_d  = skid_last_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_data_d  = xf_data;
        main_last_d  = s.last;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = xf_data;
        main_last_d  = s.last;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = xf_data;
        skid_last_d  = s.last;
      end
    end
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (drain && main_last_q) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      pkt_cnt_q    <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_last_q  <= main_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 2'd0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          mode_q <= cfg_mode_i;
          if (!s.last) state_q <= PKT;
        end
        PKT: begin
          if (s.last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_endian_rvs_stream.sv
// tb/tb_endian_rvs_stream.sv - directed self-checking bench for endian_rvs_stream
module tb_endian_rvs_stream;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  cfg_mode;
  logic        busy0, busy1, mode_chg0, mode_chg1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  int          compared;
  int          mismatched;

  endian_rvs_stream_if #(.DW(32)) s0 ();
  endian_rvs_stream_if #(.DW(32)) m0 ();
  endian_rvs_stream_if #(.DW(32)) s1 ();
  endian_rvs_stream_if #(.DW(32)) m1 ();

  assign s1.valid = s0.valid;
  assign s1.data  = s0.data;
  assign s1.last  = s0.last;
  assign m1.ready = m0.ready;

  endian_rvs_stream #(.DW(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .cfg_mode_i(cfg_mode),
    .s(s0.slave), .m(m0.master),
    .busy_o(busy0), .mode_chg_o(mode_chg0), .pkt_cnt_o(cnt0)
  );

  endian_rvs_stream #(.DW(32), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .en_i(en), .cfg_mode_i(cfg_mode),
    .s(s1.slave), .m(m1.master),
    .busy_o(busy1), .mode_chg_o(mode_chg1), .pkt_cnt_o(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; cfg_mode = 2'd0;
    s0.valid = 1'b0; s0.data = '0; s0.last = 1'b0; m0.ready = 1'b1;
    step();
    compared++;
    if (m0.valid !== 1'b0 || m0.data !== 32'h0 || m0.last !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_m: got v=%b d=%h l=%b expected 0/0/0", m0.valid, m0.data, m0.last);
    end
    compared++;
    if (busy0 !== 1'b0 || mode_chg0 !== 1'b0 || cnt0 !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_status: got busy=%b chg=%b cnt=%0d expected 0/0/0", busy0, mode_chg0, cnt0);
    end
    rst_n = 1'b1;
    #1;
    compared++;
    if (s0.ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: got %b expected 1", s0.ready);
    end
  endtask

  task automatic test_transform();
    logic [1:0]  md  [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
    logic [31:0] din [4] = '{32'h12345678, 32'h00000001, 32'h01020304, 32'hDEADBEEF};
    logic [31:0] dexp[4] = '{32'h78563412, 32'h80000000, 32'h8040C020, 32'hDEADBEEF};
    for (int i = 0; i < 4; i++) begin
      cfg_mode = md[i]; s0.data = din[i]; s0.last = 1'b1; s0.valid = 1'b1;
      step();
      s0.valid = 1'b0;
      compared++;
      if (m0.valid !== 1'b1 || m0.data !== dexp[i]) begin
        mismatched++;
        $display("FAIL transform_mode%0d: got v=%b d=%h expected v=1 d=%h", md[i], m0.valid, m0.data, dexp[i]);
      end
    end
  endtask

  task automatic test_mode_latch();
    step();
    compared++;
    if (busy0 !== 1'b0) begin
      mismatched++;
      $display("FAIL latch_busy_idle: got %b expected 0", busy0);
    end
    cfg_mode = 2'd1; s0.data = 32'h000000FF; s0.last = 1'b0; s0.valid = 1'b1;
    step();
    compared++;
    if (busy0 !== 1'b1 || m0.data !== 32'hFF000000 || mode_chg0 !== 1'b0) begin
      mismatched++;
      $display("FAIL latch_beat1: got busy=%b d=%h chg=%b expected 1/ff000000/0", busy0, m0.data, mode_chg0);
    end
    cfg_mode = 2'd2;
    #1;
    compared++;
    if (mode_chg0 !== 1'b1) begin
      mismatched++;
      $display("FAIL latch_chg_pulse: got %b expected 1", mode_chg0);
    end
    step();
    compared++;
    if (busy0 !== 1'b1 || m0.data !== 32'hFF000000) begin
      mismatched++;
      $display("FAIL latch_beat2: got busy=%b d=%h expected 1/ff000000", busy0, m0.data);
    end
    s0.last = 1'b1;
    step();
    s0.valid = 1'b0;
    compared++;
    if (busy0 !== 1'b0 || m0.data !== 32'hFF000000 || m0.last !== 1'b1 || mode_chg0 !== 1'b0) begin
      mismatched++;
      $display("FAIL latch_beat3: got busy=%b d=%h l=%b chg=%b expected 0/ff000000/1/0",
               busy0, m0.data, m0.last, mode_chg0);
    end
    cfg_mode = 2'd0;
  endtask

  task automatic test_back_to_back_backpressure();
    logic [31:0] vals[8];
    int          p, c;
    logic        hold;
    logic [31:0] held;
    p = 0; c = 0; hold = 1'b0; held = '0;
    for (int i = 0; i < 8; i++) vals[i] = 32'h1000_0000 + 32'(i);
    step();
    for (int cyc = 0; cyc < 30 && c < 8; cyc++) begin
      m0.ready = (cyc >= 3);
      s0.valid = (p < 8);
      s0.data  = vals[p % 8];
      s0.last  = (p == 7);
      #1;
      if (hold) begin
        compared++;
        if (m0.data !== held) begin
          mismatched++;
          $display("FAIL bp_stable cyc%0d: got %h expected %h", cyc, m0.data, held);
        end
      end
      if (cyc == 2) begin
        compared++;
        if (s0.ready !== 1'b0) begin
          mismatched++;
          $display("FAIL bp_ready_drop: got %b expected 0", s0.ready);
        end
      end
      if (cyc >= 3) begin
        compared++;
        if (!(m0.valid && m0.ready)) begin
          mismatched++;
          $display("FAIL bp_throughput cyc%0d: got valid=%b expected 1", cyc, m0.valid);
        end
      end
      if (m0.valid && m0.ready) begin
        compared++;
        if (m0.data !== vals[c] || m0.last !== (c == 7)) begin
          mismatched++;
          $display("FAIL bp_order beat%0d: got %h/%b expected %h/%b", c, m0.data, m0.last, vals[c], (c == 7));
        end
        c++;
      end
      hold = m0.valid && !m0.ready;
      held = m0.data;
      if (s0.valid && s0.ready) p++;
      step();
    end
    s0.valid = 1'b0;
    #1;
    compared++;
    if (c != 8 || p != 8 || m0.valid !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_count: got out=%0d in=%0d valid=%b expected 8/8/0", c, p, m0.valid);
    end
  endtask

  task automatic test_single_beat();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    compared++;
    if (cnt0 !== 16'd0 || cnt1 !== 2'd0) begin
      mismatched++;
      $display("FAIL single_cnt_clear: got %0d/%0d expected 0/0", cnt0, cnt1);
    end
    m0.ready = 1'b1; cfg_mode = 2'd0; s0.last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s0.valid = 1'b1; s0.data = 32'(i);
      step();
      compared++;
      if (busy0 !== 1'b0) begin
        mismatched++;
        $display("FAIL single_busy beat%0d: got %b expected 0", i, busy0);
      end
    end
    s0.valid = 1'b0;
    step();
    step();
    compared++;
    if (cnt0 !== 16'd5) begin
      mismatched++;
      $display("FAIL single_cnt16: got %0d expected 5", cnt0);
    end
    compared++;
    if (cnt1 !== 2'd1) begin
      mismatched++;
      $display("FAIL single_cnt_wrap: got %0d expected 1", cnt1);
    end
  endtask

  task automatic test_en_low();
    cfg_mode = 2'd3; s0.data = 32'h01020304; s0.last = 1'b0; s0.valid = 1'b1;
    step();
    compared++;
    if (busy0 !== 1'b1 || m0.data !== 32'h8040C020) begin
      mismatched++;
      $display("FAIL en_beat1: got busy=%b d=%h expected 1/8040c020", busy0, m0.data);
    end
    en = 1'b0; cfg_mode = 2'd0; s0.data = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      compared++;
      if (s0.ready !== 1'b0) begin
        mismatched++;
        $display("FAIL en_ready_low cyc%0d: got %b expected 0", i, s0.ready);
      end
      step();
      compared++;
      if (m0.valid !== 1'b0 || busy0 !== 1'b1) begin
        mismatched++;
        $display("FAIL en_drain cyc%0d: got valid=%b busy=%b expected 0/1", i, m0.valid, busy0);
      end
    end
    en = 1'b1; s0.data = 32'h01020304; s0.last = 1'b1;
    step();
    s0.valid = 1'b0;
    compared++;
    if (m0.data !== 32'h8040C020 || m0.last !== 1'b1 || busy0 !== 1'b0) begin
      mismatched++;
      $display("FAIL en_resume: got d=%h l=%b busy=%b expected 8040c020/1/0", m0.data, m0.last, busy0);
    end
    step();
    compared++;
    if (cnt0 !== 16'd6 || cnt1 !== 2'd2) begin
      mismatched++;
      $display("FAIL en_cnt: got %0d/%0d expected 6/2", cnt0, cnt1);
    end
  endtask

  task automatic test_reset_midop();
    m0.ready = 1'b0; cfg_mode = 2'd2; s0.last = 1'b0; s0.valid = 1'b1; s0.data = 32'hAABBCCDD;
    step();
    s0.data = 32'h11223344;
    step();
    s0.valid = 1'b0;
    compared++;
    if (m0.valid !== 1'b1 || s0.ready !== 1'b0 || busy0 !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_pre: got valid=%b ready=%b busy=%b expected 1/0/1", m0.valid, s0.ready, busy0);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (m0.valid !== 1'b0 || cnt0 !== 16'd0 || busy0 !== 1'b0 || m0.data !== 32'h0) begin
      mismatched++;
      $display("FAIL rst_mid: got valid=%b cnt=%0d busy=%b d=%h expected 0/0/0/0", m0.valid, cnt0, busy0, m0.data);
    end
    #1;
    rst_n = 1'b1;
    cfg_mode = 2'd1; m0.ready = 1'b1; s0.data = 32'h00000001; s0.last = 1'b1; s0.valid = 1'b1;
    step();
    s0.valid = 1'b0;
    compared++;
    if (m0.valid !== 1'b1 || m0.data !== 32'h80000000) begin
      mismatched++;
      $display("FAIL rst_post_beat: got v=%b d=%h expected 1/80000000", m0.valid, m0.data);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_transform();
    test_mode_latch();
    test_back_to_back_backpressure();
    test_single_beat();
    test_en_low();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
